pulse_period_meter: RTL and testbench
=====================================

Name: pulse_period_meter

Overview:
- Fast-domain consumer of the single-cycle event pulse produced by the slow-to-fast CDC synchroniser/edge-detect stage.
- Measures the interval, in clk2 cycles, between consecutive pulses and counts events.
- Flags a missing-event timeout.
- Presents each interval measurement on a valid/ready output port for the downstream status/CSR logic.

Parameters:
- CNT_W, 16, width of the interval counter and period_data.
- EVT_W, 16, width of the wrapping event counter.
- TIMEOUT, 16'hFFF0, interval in clk2 cycles without a pulse that raises timeout; legal range 2..2^CNT_W-1.
- AVG_LOG2, 2, log2 of measurements averaged per output; used only with PPM_AVG_EN.

Ports:
- clk2, input, 1, destination fast clock; all logic on its rising edge.
- rstn, input, 1, asynchronous active-low reset.
- enable, input, 1, level; measurement active while 1.
- clear, input, 1, synchronous one-cycle clear of flags, counters and output.
- pulse_in, input, 1, single-clk2-cycle event pulse from the synchroniser stage.
- period_data, output, CNT_W, measured interval in clk2 cycles.
- period_valid, output, 1, period_data valid.
- period_ready, input, 1, downstream accepts when valid & ready.
- evt_cnt, output, EVT_W, pulses seen while enabled; wraps.
- timeout, output, 1, sticky: no pulse within TIMEOUT cycles.
- overrun, output, 1, sticky: measurement dropped because the output was held.

Behaviour:
- Reset (rstn=0, async): state IDLE. period_data=0, period_valid=0, evt_cnt=0, timeout=0, overrun=0, interval counter=0. Reset mid-operation aborts everything, with no partial output.

FSM:
- IDLE: enable=0. pulse_in is ignored. enable=1 → ARMED next cycle.
- ARMED: waits for the first pulse. On pulse_in: evt_cnt+1, counter←1 → MEASURE. No measurement is produced.
- MEASURE: counter increments by 1 each cycle without a pulse.
  - On pulse_in: the measurement equals the current counter value; counter←1; evt_cnt+1. Stays in MEASURE.
  - If the counter reaches TIMEOUT without a pulse: timeout←1, counter←0 → ARMED. No measurement.
  - Pulses at cycles t and t+N give period N; back-to-back pulses give 1.
- enable=0 in ARMED/MEASURE → IDLE next cycle. Counter←0. The pending output is kept and its handshake continues.

Clear priority:
- clear=1 has priority over pulse_in, timeout and enable transitions.
- It zeroes evt_cnt, timeout, overrun, period_valid and the counter.
- Next state: ARMED if enable=1, else IDLE.

Output handshake:
- A measurement loads period_data and sets period_valid=1 on the next edge. Latency is 1 cycle after the pulse.
- period_data is stable while period_valid=1 and period_ready=0.
- Transfer occurs on valid&ready. period_valid falls the next cycle unless a new measurement loads in the same cycle; in that case valid stays 1 with the new data.
- New measurement while valid=1 and ready=0: the new measurement is dropped, the old data is kept, and overrun←1.

Arithmetic:
- Counter saturates at 2^CNT_W-1. It never wraps, although TIMEOUT normally fires first.
- evt_cnt wraps modulo 2^EVT_W.

Optional Feature:
- Macro: PPM_AVG_EN.
- Defined:
  - Measurements are accumulated in a CNT_W+AVG_LOG2 accumulator.
  - Every 2^AVG_LOG2 measurements, period_data is loaded with the accumulator right-shifted by AVG_LOG2, then the accumulator and its count are cleared.
  - Overrun applies to the averaged output.
  - A timeout, clear, or enable=0 discards the partial accumulation.
- Undefined: each measurement is output directly and AVG_LOG2 is unused.

Test Plan:
- Periodic pulses: enable=1, pulses every 10 cycles ×5, ready=1 → 4 outputs of period_data=10; evt_cnt=5; no timeout or overrun.
- Back-to-back: pulses on 3 consecutive cycles → outputs 1,1; evt_cnt=3.
- Backpressure: pulses every 8 cycles, ready=0 for 20 cycles → first value 8 held stable, overrun=1. Then ready=1 → a single transfer of 8, and valid drops if no new pulse arrives.
- Timeout: TIMEOUT=50, one pulse then silence → timeout=1 at 50 cycles after the pulse, state ARMED. Next pulse produces no output; the pulse after that produces a correct period.
- Clear/enable: clear asserted on the same cycle as a pulse → evt_cnt=0, no output, flags 0. enable dropped mid-MEASURE → pending valid still completes its handshake.
- Reset: rstn low while period_valid=1 → all outputs 0 asynchronously. With PPM_AVG_EN and AVG_LOG2=2, periods 10,12,10,12 → a single output of 11.

Source files
------------

// File: rtl/pulse_period_meter.sv
// pulse_period_meter
//
// Takes the single-cycle event pulse from the slow-to-fast synchroniser
// stage. It measures the number of clk2 cycles between consecutive pulses,
// counts events and flags a missing event after TIMEOUT cycles without a
// pulse. Each interval is presented on a valid/ready port.
//
// Build option:
//   PPM_AVG_EN - when defined, 2**AVG_LOG2 consecutive measurements are
//                averaged, and one averaged value is presented per group.
//                When undefined, every measurement is presented directly.
//
// Ports:
//   clk2          fast destination clock, rising edge
//   rstn          asynchronous active-low reset
//   enable        level, measurement active while high
//   clear         one-cycle synchronous clear of flags, counters and output
//   pulse_in      single-cycle event pulse
//   period_data   measured interval in clk2 cycles (CNT_W bits)
//   period_valid  period_data holds an untransferred measurement
//   period_ready  downstream accepts when valid & ready
//   evt_cnt       pulses seen while enabled, wraps (EVT_W bits)
//   timeout       sticky, no pulse arrived within TIMEOUT cycles
//   overrun       sticky, a measurement was dropped because the output was held
module pulse_period_meter #(
    parameter int              CNT_W    = 16,
    parameter int              EVT_W    = 16,
    parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(16'hFFF0),
    parameter int              AVG_LOG2 = 2
) (
    input  logic             clk2,
    input  logic             rstn,
    input  logic             enable,
    input  logic             clear,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] period_data,
    output logic             period_valid,
    input  logic             period_ready,
    output logic [EVT_W-1:0] evt_cnt,
    output logic             timeout,
    output logic             overrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [EVT_W-1:0] evt_nx;
    logic             meas;       // a full interval ends this cycle
    logic             to_event;   // interval ran out without a pulse
    logic             load;       // a value is offered to the output port
    logic [CNT_W-1:0] load_val;

    // ---------------------------------------------------------------
    // Control FSM and interval counter
    // ---------------------------------------------------------------
    always_ff @(posedge clk2 or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            evt_cnt <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            evt_cnt <= evt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        evt_nx   = evt_cnt;
        meas     = 1'b0;
        to_event = 1'b0;
        if (clear) begin
            // Clear outranks pulse, timeout and enable transitions.
            state_nx = enable ? ARMED : IDLE;
            cnt_nx   = '0;
            evt_nx   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt_nx = '0;
                    if (enable) state_nx = ARMED;
                end
                ARMED: begin
                    if (!enable) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else if (pulse_in) begin
                        // The first pulse only opens an interval.
                        state_nx = MEASURE;
                        cnt_nx   = CNT_W'(1);
                        evt_nx   = evt_cnt + EVT_W'(1);
                    end
                end
                MEASURE: begin
                    if (!enable) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else if (pulse_in) begin
                        // The counter holds the cycles since the previous
                        // pulse, so it is the measurement itself.
                        meas   = 1'b1;
                        cnt_nx = CNT_W'(1);
                        evt_nx = evt_cnt + EVT_W'(1);
                    end else if (cnt >= TIMEOUT) begin
                        to_event = 1'b1;
                        state_nx = ARMED;
                        cnt_nx   = '0;
                    end else if (cnt != '1) begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Measurement shaping (direct or averaged)
    // ---------------------------------------------------------------
`ifdef PPM_AVG_EN
    localparam int ACC_W  = CNT_W + AVG_LOG2;
    localparam int ACC_NW = AVG_LOG2 + 1;
    localparam logic [ACC_NW-1:0] ACC_LAST = ACC_NW'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [ACC_NW-1:0] acc_n;

    assign acc_sum  = acc + ACC_W'(cnt);
    assign load     = meas && (acc_n == ACC_LAST);
    assign load_val = CNT_W'(acc_sum >> AVG_LOG2);

    always_ff @(posedge clk2 or negedge rstn) begin
        if (!rstn) begin
            acc   <= '0;
            acc_n <= '0;
        end else if (clear || to_event || !enable) begin
            // A broken sequence must not contribute to the next average.
            acc   <= '0;
            acc_n <= '0;
        end else if (meas) begin
            if (load) begin
                acc   <= '0;
                acc_n <= '0;
            end else begin
                acc   <= acc_sum;
                acc_n <= acc_n + ACC_NW'(1);
            end
        end
    end
`else
    localparam int unused_avg_log2 = AVG_LOG2;

    assign load     = meas;
    assign load_val = cnt;
`endif

    // ---------------------------------------------------------------
    // Output port and sticky flags
    // ---------------------------------------------------------------
    always_ff @(posedge clk2 or negedge rstn) begin
        if (!rstn) begin
            period_data  <= '0;
            period_valid <= 1'b0;
            overrun      <= 1'b0;
        end else if (clear) begin
            period_data  <= '0;
            period_valid <= 1'b0;
            overrun      <= 1'b0;
        end else if (load && period_valid && !period_ready) begin
            // Held output keeps its data; the new value is lost.
            overrun <= 1'b1;
        end else if (load) begin
            // Also covers a transfer and a new load in the same cycle.
            period_data  <= load_val;
            period_valid <= 1'b1;
        end else if (period_valid && period_ready) begin
            period_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk2 or negedge rstn) begin
        if (!rstn) begin
            timeout <= 1'b0;
        end else if (clear) begin
            timeout <= 1'b0;
        end else if (to_event) begin
            timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter (TIMEOUT = 50, widths 16).
// Inputs are changed 1 time unit after a rising edge; outputs are
// checked 1 time unit after the following rising edge.
module tb_pulse_period_meter;

    logic        clk2;
    logic        rstn;
    logic        enable;
    logic        clear;
    logic        pulse_in;
    logic [15:0] period_data;
    logic        period_valid;
    logic        period_ready;
    logic [15:0] evt_cnt;
    logic        timeout;
    logic        overrun;

    int n_vec;
    int n_bad;

    pulse_period_meter #(
        .CNT_W   (16),
        .EVT_W   (16),
        .TIMEOUT (16'd50),
        .AVG_LOG2(2)
    ) dut (
        .clk2        (clk2),
        .rstn        (rstn),
        .enable      (enable),
        .clear       (clear),
        .pulse_in    (pulse_in),
        .period_data (period_data),
        .period_valid(period_valid),
        .period_ready(period_ready),
        .evt_cnt     (evt_cnt),
        .timeout     (timeout),
        .overrun     (overrun)
    );

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    typedef struct {
        logic        en;
        logic        clr;
        logic        pl;
        logic        rdy;
        logic        ev;
        logic [15:0] ed;
        logic [15:0] ee;
        logic        eto;
        logic        eov;
    } vec_t;

    vec_t tbl[8];

    task automatic tick(input logic en, input logic clr, input logic pl, input logic rdy);
        enable       = en;
        clear        = clr;
        pulse_in     = pl;
        period_ready = rdy;
        @(posedge clk2);
        #1;
    endtask

    // cd selects whether period_data is compared (meaningless while valid=0)
    task automatic check(input string nm, input logic cd, input logic ev, input logic [15:0] ed,
                         input logic [15:0] ee, input logic eto, input logic eov);
        n_vec++;
        if (period_valid !== ev || (cd && period_data !== ed) || evt_cnt !== ee ||
            timeout !== eto || overrun !== eov) begin
            n_bad++;
            $display("FAIL %s: got valid=%0b data=%0d evt=%0d timeout=%0b overrun=%0b, want valid=%0b data=%0d evt=%0d timeout=%0b overrun=%0b",
                     nm, period_valid, period_data, evt_cnt, timeout, overrun, ev, ed, ee, eto, eov);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec        = 0;
        n_bad        = 0;
        rstn         = 1'b0;
        enable       = 1'b0;
        clear        = 1'b0;
        pulse_in     = 1'b0;
        period_ready = 1'b0;
        #12;
        check("reset_state", 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        @(negedge clk2);
        rstn = 1'b1;

        // Pulse while disabled is ignored.
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        check("idle_ignores_pulse", 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);

`ifndef PPM_AVG_EN
        // ---- periodic pulses every 10 cycles, five pulses ----
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        check("arm", 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        check("periodic_first_pulse", 1'b0, 1'b0, 16'd0, 16'd1, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            repeat (9) tick(1'b1, 1'b0, 1'b0, 1'b1);
            check("periodic_gap", 1'b0, 1'b0, 16'd0, 16'(k), 1'b0, 1'b0);
            tick(1'b1, 1'b0, 1'b1, 1'b1);
            check("periodic_out", 1'b1, 1'b1, 16'd10, 16'(k + 1), 1'b0, 1'b0);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        check("periodic_drained", 1'b0, 1'b0, 16'd0, 16'd5, 1'b0, 1'b0);

        // ---- back-to-back pulses and clear colliding with a pulse ----
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'd1, 16'd2, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'd1, 16'd3, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd3, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            tick(tbl[i].en, tbl[i].clr, tbl[i].pl, tbl[i].rdy);
            check($sformatf("table_row%0d", i), tbl[i].ev, tbl[i].ev, tbl[i].ed,
                  tbl[i].ee, tbl[i].eto, tbl[i].eov);
        end

        // ---- backpressure: pulses every 8 cycles, ready low ----
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        check("bp_clear", 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        check("bp_first_pulse", 1'b0, 1'b0, 16'd0, 16'd1, 1'b0, 1'b0);
        repeat (7) tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        check("bp_first_value", 1'b1, 1'b1, 16'd8, 16'd2, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0);
            check("bp_held", 1'b1, 1'b1, 16'd8, 16'd2, 1'b0, 1'b0);
        end
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        check("bp_overrun", 1'b1, 1'b1, 16'd8, 16'd3, 1'b0, 1'b1);
        repeat (4) tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("bp_still_held", 1'b1, 1'b1, 16'd8, 16'd3, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        check("bp_transfer", 1'b0, 1'b0, 16'd0, 16'd3, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        check("bp_single_transfer", 1'b0, 1'b0, 16'd0, 16'd3, 1'b0, 1'b1);

        // ---- timeout after 50 silent cycles ----
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        check("to_clear", 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        repeat (49) tick(1'b1, 1'b0, 1'b0, 1'b1);
        check("to_not_yet", 1'b0, 1'b0, 16'd0, 16'd1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        check("to_fires", 1'b0, 1'b0, 16'd0, 16'd1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        check("to_rearm_pulse", 1'b0, 1'b0, 16'd0, 16'd2, 1'b1, 1'b0);
        repeat (9) tick(1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        check("to_after_period", 1'b1, 1'b1, 16'd10, 16'd3, 1'b1, 1'b0);

        // ---- enable drop with a pending output ----
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (4) tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        check("en_value", 1'b1, 1'b1, 16'd5, 16'd2, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("en_drop_keeps", 1'b1, 1'b1, 16'd5, 16'd2, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        check("en_idle_pulse", 1'b1, 1'b1, 16'd5, 16'd2, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        check("en_handshake", 1'b0, 1'b0, 16'd0, 16'd2, 1'b0, 1'b0);

        // ---- reset while valid ----
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        check("rst_pre_value", 1'b1, 1'b1, 16'd3, 16'd2, 1'b0, 1'b0);
`else
        // ---- averaging: periods 10,12,10,12 give one output of 11 ----
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        check("avg_clear", 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        check("avg_first_pulse", 1'b0, 1'b0, 16'd0, 16'd1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            repeat ((k % 2 == 0) ? 9 : 11) tick(1'b1, 1'b0, 1'b0, 1'b1);
            tick(1'b1, 1'b0, 1'b1, 1'b1);
            if (k < 3)
                check("avg_partial", 1'b0, 1'b0, 16'd0, 16'(k + 2), 1'b0, 1'b0);
            else
                check("avg_out", 1'b1, 1'b1, 16'd11, 16'd5, 1'b0, 1'b0);
        end
        period_ready = 1'b0;
`endif

        // Asynchronous reset, applied away from any clock edge.
        #3;
        rstn = 1'b0;
        #1;
        check("async_reset", 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        check("reset_held", 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        @(negedge clk2);
        rstn = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
